pc_stepper: RTL and testbench

Program-counter sequencer fed by the 1 Hz divided clock. Samples the slow clock in the fast domain and converts each rising edge into a one-cycle advance tick. Steps a PC_WIDTH-bit program counter in free-run or single-step mode, with synchronous load and wrap reporting. Sits directly downstream of the frequency divider and drives the PC and display logic.

---
 rtl/pc_stepper_pkg.sv | 12 +
 rtl/pc_stepper_sync_edge_detect.sv | 35 +++
 rtl/pc_stepper.sv | 99 +++++++++
 tb/tb_pc_stepper.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_stepper_pkg.sv
// rtl/pc_stepper_pkg.sv - shared types and constants for the PC stepper
package pc_stepper_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam int DEFAULT_PC_WIDTH = 8;

endpackage

// File: rtl/pc_stepper_sync_edge_detect.sv
// rtl/pc_stepper_sync_edge_detect.sv - three-flop synchronizer with rising-edge pulse
module sync_edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic in_clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Resetting high means an input already high at release never looks like an edge.
  always_ff @(posedge in_clk) begin
    if (!rst_n) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
      s3_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/pc_stepper.sv
// rtl/pc_stepper.sv - program counter sequencer advanced by the divided clock
module pc_stepper
  import pc_stepper_pkg::*;
#(
  parameter int PC_WIDTH   = DEFAULT_PC_WIDTH,
  parameter int RESET_ADDR = 0,
  parameter int STEP       = 1
) (
  input  logic                in_clk,
  input  logic                rst_n,
  input  logic                slow_clk,
  input  logic                run,
  input  logic                step_btn,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_addr,
  output logic [PC_WIDTH-1:0] pc,
  output logic                pc_upd,
  output logic                wrap,
  output logic                running
);

  localparam logic [PC_WIDTH:0]   STEP_EXT = (PC_WIDTH + 1)'(STEP);
  localparam logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_ADDR);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                pc_upd_q, pc_upd_d;
  logic                wrap_q, wrap_d;
  logic                tick, step_req, advance;
  logic [PC_WIDTH:0]   sum;

  sync_edge_detect #(.RESET_VAL(1'b1)) u_tick_sync (
    .in_clk (in_clk),
    .rst_n  (rst_n),
    .d      (slow_clk),
    .rise   (tick)
  );

  sync_edge_detect #(.RESET_VAL(1'b1)) u_step_sync (
    .in_clk (in_clk),
    .rst_n  (rst_n),
    .d      (step_btn),
    .rise   (step_req)
  );

  always_comb begin
    sum      = {1'b0, pc_q} + STEP_EXT;
    advance  = tick & ((state_q == ST_RUN) | (state_q == ST_STEP));
    state_d  = state_q;
    pc_d     = pc_q;
    pc_upd_d = 1'b0;
    wrap_d   = 1'b0;
    // A load swallows any coincident tick, so a pending step survives it.
    if (load) begin
      pc_d     = load_addr;
      pc_upd_d = 1'b1;
    end else begin
      if (advance) begin
        pc_d     = sum[PC_WIDTH-1:0];
        pc_upd_d = 1'b1;
        wrap_d   = sum[PC_WIDTH];
      end
      case (state_q)
        ST_HALT: begin
          if (run)           state_d = ST_RUN;
          else if (step_req) state_d = ST_STEP;
        end
        ST_STEP: begin
          if (run)       state_d = ST_RUN;
          else if (tick) state_d = ST_HALT;
        end
        ST_RUN: begin
          if (!run) state_d = ST_HALT;
        end
        default: state_d = ST_HALT;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (!rst_n) begin
      state_q  <= ST_HALT;
      pc_q     <= RESET_PC;
      pc_upd_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_upd_q <= pc_upd_d;
      wrap_q   <= wrap_d;
    end
  end

  assign pc      = pc_q;
  assign pc_upd  = pc_upd_q;
  assign wrap    = wrap_q;
  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_pc_stepper.sv
// tb/tb_pc_stepper.sv - directed self-checking bench for pc_stepper
module tb_pc_stepper;

  logic       clk;
  logic       rst_n;
  logic       slow_clk;
  logic       run;
  logic       step_btn;
  logic       load;
  logic [7:0] load_addr;
  logic [7:0] pc;
  logic       pc_upd;
  logic       wrap;
  logic       running;

  int passed;
  int total;

  pc_stepper #(.PC_WIDTH(8), .RESET_ADDR(0), .STEP(1)) dut (
    .in_clk    (clk),
    .rst_n     (rst_n),
    .slow_clk  (slow_clk),
    .run       (run),
    .step_btn  (step_btn),
    .load      (load),
    .load_addr (load_addr),
    .pc        (pc),
    .pc_upd    (pc_upd),
    .wrap      (wrap),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One slow_clk low/high period; pc must move exactly at the third edge after the rise.
  task automatic do_rise(input string name, input logic [7:0] prev_pc,
                         input logic [7:0] exp_pc, input logic exp_upd, input logic exp_wrap);
    slow_clk = 1'b0;
    cyc(5);
    slow_clk = 1'b1;
    cyc(2);
    total++;
    if ({pc, pc_upd} !== {prev_pc, 1'b0})
      $display("FAIL %s_early pc=%h pc_upd=%b expected pc=%h pc_upd=0", name, pc, pc_upd, prev_pc);
    else passed++;
    cyc(1);
    total++;
    if ({pc, pc_upd, wrap} !== {exp_pc, exp_upd, exp_wrap})
      $display("FAIL %s_update pc=%h pc_upd=%b wrap=%b expected pc=%h pc_upd=%b wrap=%b",
               name, pc, pc_upd, wrap, exp_pc, exp_upd, exp_wrap);
    else passed++;
    cyc(1);
    total++;
    if ({pc_upd, wrap} !== 2'b00)
      $display("FAIL %s_pulse pc_upd=%b wrap=%b expected 0 0", name, pc_upd, wrap);
    else passed++;
    cyc(2);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    slow_clk  = 1'b1;
    step_btn  = 1'b1;
    run       = 1'b0;
    load      = 1'b0;
    load_addr = 8'h00;
    cyc(2);
    total++;
    if ({pc, pc_upd, wrap, running} !== {8'h00, 3'b000})
      $display("FAIL reset_state pc=%h upd=%b wrap=%b running=%b expected 00 0 0 0",
               pc, pc_upd, wrap, running);
    else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      total++;
      if ({pc, pc_upd, wrap, running} !== {8'h00, 3'b000})
        $display("FAIL reset_quiet cycle %0d pc=%h upd=%b wrap=%b running=%b expected 00 0 0 0",
                 i, pc, pc_upd, wrap, running);
      else passed++;
    end
  endtask

  task automatic test_free_run();
    slow_clk = 1'b0;
    step_btn = 1'b0;
    cyc(5);
    run = 1'b1;
    cyc(1);
    total++;
    if (running !== 1'b1) $display("FAIL run_enter running=%b expected 1", running);
    else passed++;
    do_rise("run1", 8'h00, 8'h01, 1'b1, 1'b0);
    do_rise("run2", 8'h01, 8'h02, 1'b1, 1'b0);
    do_rise("run3", 8'h02, 8'h03, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    load_addr = 8'hFE;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    total++;
    if ({pc, pc_upd, wrap, running} !== {8'hFE, 3'b101})
      $display("FAIL wrap_load pc=%h upd=%b wrap=%b running=%b expected fe 1 0 1",
               pc, pc_upd, wrap, running);
    else passed++;
    do_rise("wrap_ff", 8'hFE, 8'hFF, 1'b1, 1'b0);
    do_rise("wrap_00", 8'hFF, 8'h00, 1'b1, 1'b1);
    do_rise("wrap_01", 8'h00, 8'h01, 1'b1, 1'b0);
    run = 1'b0;
    cyc(1);
    total++;
    if (running !== 1'b0) $display("FAIL halt_enter running=%b expected 0", running);
    else passed++;
    do_rise("halt_idle", 8'h01, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_single_step();
    step_btn = 1'b1;
    cyc(3);
    step_btn = 1'b0;
    cyc(4);
    step_btn = 1'b1;
    cyc(4);
    total++;
    if ({pc, pc_upd, running} !== {8'h01, 2'b00})
      $display("FAIL step_wait pc=%h upd=%b running=%b expected 01 0 0", pc, pc_upd, running);
    else passed++;
    do_rise("step_first", 8'h01, 8'h02, 1'b1, 1'b0);
    do_rise("step_second", 8'h02, 8'h02, 1'b0, 1'b0);
    do_rise("step_third", 8'h02, 8'h02, 1'b0, 1'b0);
    step_btn = 1'b0;
    cyc(4);
  endtask

  task automatic test_load_vs_tick();
    run = 1'b1;
    cyc(1);
    slow_clk = 1'b0;
    cyc(5);
    slow_clk = 1'b1;
    cyc(2);
    load_addr = 8'h40;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    total++;
    if ({pc, pc_upd, wrap, running} !== {8'h40, 3'b101})
      $display("FAIL load_tick pc=%h upd=%b wrap=%b running=%b expected 40 1 0 1",
               pc, pc_upd, wrap, running);
    else passed++;
    cyc(3);
    do_rise("after_load", 8'h40, 8'h41, 1'b1, 1'b0);
    load_addr = 8'h41;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    total++;
    if ({pc, pc_upd} !== {8'h41, 1'b1})
      $display("FAIL load_same pc=%h upd=%b expected 41 1", pc, pc_upd);
    else passed++;
    cyc(1);
  endtask

  task automatic test_reset_mid_run();
    load_addr = 8'h99;
    load  = 1'b1;
    rst_n = 1'b0;
    cyc(1);
    total++;
    if ({pc, pc_upd, wrap, running} !== {8'h00, 3'b000})
      $display("FAIL reset_vs_load pc=%h upd=%b wrap=%b running=%b expected 00 0 0 0",
               pc, pc_upd, wrap, running);
    else passed++;
    load  = 1'b0;
    rst_n = 1'b1;
    cyc(1);
    total++;
    if ({pc, pc_upd, running} !== {8'h00, 2'b01})
      $display("FAIL reset_rerun pc=%h upd=%b running=%b expected 00 0 1", pc, pc_upd, running);
    else passed++;
    do_rise("post_reset", 8'h00, 8'h01, 1'b1, 1'b0);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_free_run();
    test_wrap();
    test_single_step();
    test_load_vs_tick();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
